// File: rtl/synth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : synth_pkg
//  Description : Shared types and constants for the sequencer / synth path.
//                Provides the stored entry layout, the sequencer state
//                encoding and the note code constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package synth_pkg;

  // One recorded note: {note[2:0], octave[1:0], accident}
  typedef struct packed {
    logic [2:0] note;
    logic [1:0] octave;
    logic       accident;
  } seq_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REC  = 2'd1,
    PLAY = 2'd2
  } seq_state_t;

  // Note codes as presented by the keypad
  localparam logic [2:0] NOTE_C    = 3'd0;
  localparam logic [2:0] NOTE_D    = 3'd1;
  localparam logic [2:0] NOTE_E    = 3'd2;
  localparam logic [2:0] NOTE_F    = 3'd3;
  localparam logic [2:0] NOTE_G    = 3'd4;
  localparam logic [2:0] NOTE_A    = 3'd5;
  localparam logic [2:0] NOTE_B    = 3'd6;
  localparam logic [2:0] NOTE_C_HI = 3'd7;

endpackage
`default_nettype wire

// File: rtl/track_sequencer_step_timer.sv
`default_nettype none
// ============================================================================
//  Module      : step_timer
//  Description : Free-running step counter 0..STEP_CYCLES-1. tick is high
//                while the counter sits at its last value; clr forces the
//                count back to 0 and masks the tick in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module step_timer #(
  parameter int STEP_CYCLES = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(STEP_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  // Count up, wrapping after the last value or on an explicit clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == c_last)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = !clr && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/track_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : track_sequencer
//  Description : Two-track note recorder / player. Records live key presses
//                into per-track memories and replays both tracks at a fixed
//                step tempo, driving the display and tone generator.
//                Build option: define SEQ_LOOP_EN to make tracks loop at
//                their end instead of stopping.
//  Revision    : 1.0 - initial release
// ============================================================================
module track_sequencer
  import synth_pkg::*;
#(
  parameter int DEPTH       = 32,
  parameter int STEP_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] key_note,
  input  logic [1:0] key_octave,
  input  logic       key_accident,
  input  logic       key_press,
  input  logic       track_sel,
  input  logic       rec_btn,
  input  logic       play_btn,
  input  logic       stop_btn,
  output logic [2:0] note,
  output logic [1:0] octave,
  output logic       accident,
  output logic       note_on,
  output logic [1:0] track_playing,
  output logic       current_track,
  output logic       rec_active
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] c_full    = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] c_len_one = (PTR_W+1)'(1);

  seq_state_t       r_state;
  logic             r_rec_trk;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_len    [2];
  logic [PTR_W-1:0] r_rd_ptr [2];
  logic [1:0]       r_playing;
  seq_entry_t       r_out;
  logic             r_note_on;
  logic             r_cur;
  logic             r_rec_active;

  seq_entry_t       w_key_entry;
  seq_entry_t       w_rd_entry [2];
  logic [1:0]       w_len_nz;
  logic             w_wr_ok;
  logic             w_play_start;
  logic             w_tick;

  assign w_key_entry = '{note: key_note, octave: key_octave, accident: key_accident};
  assign w_len_nz    = {(r_len[1] != '0), (r_len[0] != '0)};

  // A press is stored only while recording, not on a stop cycle, and not once full
  assign w_wr_ok = (r_state == REC) && key_press && !stop_btn && (r_len[r_rec_trk] != c_full);

  // Playback (re)start: from IDLE when something is recorded, or a restart in PLAY
  assign w_play_start = !stop_btn && play_btn &&
                        (((r_state == IDLE) && !rec_btn && (w_len_nz != 2'b00)) ||
                         (r_state == PLAY));

  step_timer #(
    .STEP_CYCLES (STEP_CYCLES)
  ) u_step_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_play_start),
    .tick  (w_tick)
  );

  genvar t;
  generate
    for (t = 0; t < 2; t++) begin : g_track
      seq_entry_t r_mem [DEPTH];

      // Track memory write; contents are only ever read below len
      always_ff @(posedge clk) begin
        if (w_wr_ok && (r_rec_trk == 1'(t))) begin
          r_mem[r_wr_ptr] <= w_key_entry;
        end
      end

      assign w_rd_entry[t] = r_mem[r_rd_ptr[t]];
    end
  endgenerate

  // Sequencer FSM with registered display / synth outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_rec_trk    <= 1'b0;
      r_wr_ptr     <= '0;
      r_len[0]     <= '0;
      r_len[1]     <= '0;
      r_rd_ptr[0]  <= '0;
      r_rd_ptr[1]  <= '0;
      r_playing    <= 2'b00;
      r_out        <= '{note: NOTE_C, octave: 2'd0, accident: 1'b0};
      r_note_on    <= 1'b0;
      r_cur        <= 1'b0;
      r_rec_active <= 1'b0;
    end else begin
      r_cur     <= track_sel;
      // Live echo is the default; PLAY overrides it with the stored entry
      r_out     <= w_key_entry;
      r_note_on <= key_press;

      case (r_state)
        IDLE: begin
          if (stop_btn) begin
            r_state <= IDLE;
          end else if (rec_btn) begin
            r_state          <= REC;
            r_rec_trk        <= track_sel;
            r_len[track_sel] <= '0;
            r_wr_ptr         <= '0;
            r_rec_active     <= 1'b1;
          end else if (w_play_start) begin
            r_state     <= PLAY;
            r_rd_ptr[0] <= '0;
            r_rd_ptr[1] <= '0;
            r_playing   <= w_len_nz;
          end
        end

        REC: begin
          if (stop_btn) begin
            r_state      <= IDLE;
            r_rec_active <= 1'b0;
          end else if (w_wr_ok) begin
            r_wr_ptr         <= r_wr_ptr + 1'b1;
            r_len[r_rec_trk] <= r_len[r_rec_trk] + c_len_one;
          end
        end

        PLAY: begin
          if (stop_btn) begin
            r_state   <= IDLE;
            r_playing <= 2'b00;
            r_note_on <= 1'b0;
          end else if (w_play_start) begin
            r_rd_ptr[0] <= '0;
            r_rd_ptr[1] <= '0;
            r_playing   <= w_len_nz;
          end else if (r_playing == 2'b00) begin
            r_state <= IDLE;
          end else if (w_tick) begin
            for (int i = 0; i < 2; i++) begin
              if (r_playing[i]) begin
                if ({1'b0, r_rd_ptr[i]} == (r_len[i] - c_len_one)) begin
`ifdef SEQ_LOOP_EN
                  r_rd_ptr[i] <= '0;
`else
                  r_playing[i] <= 1'b0;
`endif
                end else begin
                  r_rd_ptr[i] <= r_rd_ptr[i] + 1'b1;
                end
              end
            end
          end

          if (!stop_btn && r_playing[r_cur]) begin
            r_out     <= w_rd_entry[r_cur];
            r_note_on <= 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign note          = r_out.note;
  assign octave        = r_out.octave;
  assign accident      = r_out.accident;
  assign note_on       = r_note_on;
  assign track_playing = r_playing;
  assign current_track = r_cur;
  assign rec_active    = r_rec_active;

endmodule
`default_nettype wire

// File: tb/tb_track_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_track_sequencer
//  Description : Self-checking bench for track_sequencer (DEPTH=4,
//                STEP_CYCLES=4). Expected output words are pushed to a
//                scoreboard queue when stimulus is applied and popped when
//                the registered outputs are sampled one edge later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_track_sequencer;

  localparam int DEPTH = 4;
  localparam int STEP  = 4;
`ifdef SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  localparam logic [5:0] LIVE = 6'b111_00_0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] key_note = '0;
  logic [1:0] key_octave = '0;
  logic       key_accident = 1'b0;
  logic       key_press = 1'b0;
  logic       track_sel = 1'b0;
  logic       rec_btn = 1'b0;
  logic       play_btn = 1'b0;
  logic       stop_btn = 1'b0;
  logic [2:0] note;
  logic [1:0] octave;
  logic       accident;
  logic       note_on;
  logic [1:0] track_playing;
  logic       current_track;
  logic       rec_active;

  int errors = 0;
  int checks = 0;

  logic [8:0] sb [$];
  logic [8:0] exp_v;
  logic [8:0] obs;
  logic [5:0] mdl_mem [2][DEPTH];
  int         mdl_len [2];
  logic [5:0] keys_tbl [8];

  assign obs = {note_on, track_playing, note, octave, accident};

  track_sequencer #(
    .DEPTH       (DEPTH),
    .STEP_CYCLES (STEP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_note      (key_note),
    .key_octave    (key_octave),
    .key_accident  (key_accident),
    .key_press     (key_press),
    .track_sel     (track_sel),
    .rec_btn       (rec_btn),
    .play_btn      (play_btn),
    .stop_btn      (stop_btn),
    .note          (note),
    .octave        (octave),
    .accident      (accident),
    .note_on       (note_on),
    .track_playing (track_playing),
    .current_track (current_track),
    .rec_active    (rec_active)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model of playback: k = cycles after the play_btn edge (k=0 is that edge)
  function automatic logic [8:0] play_exp(input int k, input bit d);
    logic [1:0] pl;
    logic [5:0] e;
    logic       on;
    bit         old;
    for (int t = 0; t < 2; t++) begin
      pl[t] = LOOP ? (mdl_len[t] != 0) : (k < STEP * mdl_len[t]);
    end
    e  = LIVE;
    on = 1'b0;
    if (k > 0) begin
      old = LOOP ? (mdl_len[d] != 0) : ((k - 1) < STEP * mdl_len[d]);
      if (old) begin
        e  = mdl_mem[d][((k - 1) / STEP) % mdl_len[d]];
        on = 1'b1;
      end
    end
    return {on, pl, e};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) cyc();
    checks++;
    if (obs !== 9'd0) begin errors++; $display("FAIL reset_outs obs=%h exp=%h", obs, 9'd0); end
    checks++;
    if ({current_track, rec_active} !== 2'b00) begin
      errors++; $display("FAIL reset_flags obs=%b exp=00", {current_track, rec_active});
    end
    rst_n = 1'b1;
    mdl_len[0] = 0;
    mdl_len[1] = 0;
    cyc();
  endtask

  task automatic test_idle_echo();
    {key_note, key_octave, key_accident} = 6'b101_11_1;
    key_press = 1'b1;
    sb.push_back({1'b1, 2'b00, 6'b101_11_1});
    cyc();
    key_press = 1'b0;
    exp_v = sb.pop_front();
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL idle_press obs=%h exp=%h", obs, exp_v); end
    sb.push_back({1'b0, 2'b00, 6'b101_11_1});
    cyc();
    exp_v = sb.pop_front();
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL idle_hold obs=%h exp=%h", obs, exp_v); end
    {key_note, key_octave, key_accident} = 6'b011_00_0;
    sb.push_back({1'b0, 2'b00, 6'b011_00_0});
    cyc();
    exp_v = sb.pop_front();
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL idle_follow obs=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_record(input bit trk, input int n, input bit swap_sel);
    track_sel = trk;
    {key_note, key_octave, key_accident} = 6'd0;
    rec_btn = 1'b1;
    sb.push_back(9'd0);
    cyc();
    rec_btn = 1'b0;
    exp_v = sb.pop_front();
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL rec_start obs=%h exp=%h", obs, exp_v); end
    checks++;
    if (rec_active !== 1'b1) begin errors++; $display("FAIL rec_active_on obs=%b exp=1", rec_active); end
    mdl_len[trk] = 0;
    for (int i = 0; i < n; i++) begin
      {key_note, key_octave, key_accident} = keys_tbl[i];
      key_press = 1'b1;
      if (swap_sel && i == 1) track_sel = ~trk;
      sb.push_back({1'b1, 2'b00, keys_tbl[i]});
      if (mdl_len[trk] < DEPTH) begin
        mdl_mem[trk][mdl_len[trk]] = keys_tbl[i];
        mdl_len[trk]++;
      end
      cyc();
      key_press = 1'b0;
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL rec_echo[%0d] obs=%h exp=%h", i, obs, exp_v); end
      if (swap_sel && i == 1) begin
        checks++;
        if (current_track !== ~trk) begin
          errors++; $display("FAIL rec_cur_track obs=%b exp=%b", current_track, ~trk);
        end
      end
      sb.push_back({1'b0, 2'b00, keys_tbl[i]});
      cyc();
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL rec_hold[%0d] obs=%h exp=%h", i, obs, exp_v); end
    end
    stop_btn = 1'b1;
    sb.push_back({1'b0, 2'b00, keys_tbl[n-1]});
    cyc();
    stop_btn = 1'b0;
    exp_v = sb.pop_front();
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL rec_stop obs=%h exp=%h", obs, exp_v); end
    checks++;
    if (rec_active !== 1'b0) begin errors++; $display("FAIL rec_active_off obs=%b exp=0", rec_active); end
    track_sel = trk;
  endtask

  task automatic test_playback(input bit d);
    int n_cyc;
    track_sel = d;
    {key_note, key_octave, key_accident} = LIVE;
    key_press = 1'b0;
    n_cyc = STEP * ((mdl_len[0] > mdl_len[1]) ? mdl_len[0] : mdl_len[1]) + 3;
    for (int k = 0; k < n_cyc; k++) begin
      play_btn = (k == 0);
      sb.push_back(play_exp(k, d));
      cyc();
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL play_t%0d[%0d] obs=%h exp=%h", d, k, obs, exp_v); end
    end
    play_btn = 1'b0;
    stop_btn = 1'b1;
    sb.push_back({1'b0, 2'b00, LIVE});
    cyc();
    stop_btn = 1'b0;
    exp_v = sb.pop_front();
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL play_stop obs=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_priority();
    {key_note, key_octave, key_accident} = LIVE;
    track_sel = 1'b1;
    rec_btn = 1'b1;
    sb.push_back({1'b0, 2'b00, LIVE});
    cyc();
    rec_btn = 1'b0;
    mdl_len[1] = 0;
    exp_v = sb.pop_front();
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL prio_rec obs=%h exp=%h", obs, exp_v); end
    stop_btn = 1'b1;
    play_btn = 1'b1;
    sb.push_back({1'b0, 2'b00, LIVE});
    cyc();
    stop_btn = 1'b0;
    play_btn = 1'b0;
    exp_v = sb.pop_front();
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL prio_stop obs=%h exp=%h", obs, exp_v); end
    checks++;
    if (rec_active !== 1'b0) begin errors++; $display("FAIL prio_rec_active obs=%b exp=0", rec_active); end
    for (int i = 0; i < 3; i++) begin
      sb.push_back({1'b0, 2'b00, LIVE});
      cyc();
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL prio_noplay[%0d] obs=%h exp=%h", i, obs, exp_v); end
    end
  endtask

  task automatic test_reset_mid_play();
    track_sel = 1'b0;
    {key_note, key_octave, key_accident} = LIVE;
    play_btn = 1'b1;
    cyc();
    play_btn = 1'b0;
    repeat (5) cyc();
    checks++;
    if (track_playing !== 2'b01) begin errors++; $display("FAIL mid_play_run obs=%b exp=01", track_playing); end
    rst_n = 1'b0;
    #2;
    checks++;
    if (obs !== 9'd0) begin errors++; $display("FAIL mid_play_reset obs=%h exp=%h", obs, 9'd0); end
    cyc();
    rst_n = 1'b1;
    mdl_len[0] = 0;
    mdl_len[1] = 0;
    play_btn = 1'b1;
    sb.push_back({1'b0, 2'b00, LIVE});
    cyc();
    play_btn = 1'b0;
    exp_v = sb.pop_front();
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL rst_play_ignored obs=%h exp=%h", obs, exp_v); end
    sb.push_back({1'b0, 2'b00, LIVE});
    cyc();
    exp_v = sb.pop_front();
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL rst_still_idle obs=%h exp=%h", obs, exp_v); end
  endtask

  initial begin
    test_reset();
    test_idle_echo();

    // Track 0: three notes, track_sel toggled mid-recording
    keys_tbl[0] = {3'd2, 2'd1, 1'b0};
    keys_tbl[1] = {3'd4, 2'd1, 1'b1};
    keys_tbl[2] = {3'd0, 2'd2, 1'b0};
    test_record(1'b0, 3, 1'b1);
    test_playback(1'b0);

    // Track 1: six presses into a four-entry track
    for (int i = 0; i < 6; i++) begin
      keys_tbl[i] = {3'((i + 3) % 8), 2'(i % 4), 1'(i % 2)};
    end
    test_record(1'b1, 6, 1'b0);
    test_playback(1'b1);

    test_priority();
    test_reset_mid_play();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/track_sequencer.md
Name: track_sequencer

Overview:
- Two-track note recorder/player sitting directly upstream of the seven-segment display stage and the tone generator.
- Captures live key presses (note, octave, accidental) into per-track memories, then replays both tracks at a fixed step tempo.
- Drives the display and synth with the current note, octave, accidental, per-track playing flags and the selected track.

Parameters:
DEPTH, 32, entries per track (power of two, >=2)
STEP_CYCLES, 25000000, clk cycles per playback step (4 Hz at 100 MHz)
PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
key_note  in  3  live note code 0..7 (C..B, high C)
key_octave  in  2  live octave code 0..3
key_accident  in  1  live sharp flag
key_press  in  1  single-cycle pulse, key event
track_sel  in  1  selected track (level)
rec_btn  in  1  single-cycle pulse, start recording selected track
play_btn  in  1  single-cycle pulse, start playback
stop_btn  in  1  single-cycle pulse, stop record/playback
note  out  3  note code to display/synth
octave  out  2  octave code
accident  out  1  sharp flag
note_on  out  1  tone enable
track_playing  out  2  bit t = track t currently playing
current_track  out  1  registered copy of track_sel
rec_active  out  1  high in REC

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; len[0]=len[1]=0; pointers 0; step counter 0. Memory contents undefined, never read beyond len.
- Entry format: {note[2:0], octave[1:0], accident}. Memory uses combinational read; all outputs are registered (1-cycle latency from any input or state change).
- States: IDLE, REC, PLAY. Button priority when simultaneous: stop > rec > play.
- IDLE:
  - Outputs follow live keys; note_on=1 on the cycle after key_press, else 0.
  - rec_btn -> REC: rec_trk latched from track_sel; len[rec_trk] cleared to 0; wr_ptr=0.
  - play_btn -> PLAY if len[0]|len[1] nonzero, else ignored.
- REC:
  - key_press writes the entry at wr_ptr and increments wr_ptr and len; live echo to outputs as in IDLE.
  - At len==DEPTH (full), further presses are ignored (no write, no wrap); the state stays REC.
  - track_sel changes update current_track only; rec_trk is unchanged.
  - rec_btn and play_btn are ignored. stop_btn -> IDLE.
- PLAY:
  - On entry: rd_ptr[t]=0 and step counter=0; track_playing[t]=(len[t]!=0).
  - Step counter counts 0..STEP_CYCLES-1. The tick fires when the counter is at STEP_CYCLES-1, and the counter then wraps to 0.
  - On a tick, each playing track advances rd_ptr; at rd_ptr==len[t]-1 the end-of-track rule applies (see Optional Feature).
  - Outputs show the entry at rd_ptr[current_track] when that track is playing, else the live keys. note_on=1 while the displayed track is playing.
  - key_press is ignored for recording. rec_btn is ignored. play_btn restarts playback from 0.
  - stop_btn -> IDLE: track_playing=0, note_on=0 next cycle.
- len is PTR_W+1 bits so it can represent DEPTH. Pointers are PTR_W bits.
- Reset mid-operation: immediate return to reset values; recorded lengths are lost.

Optional Feature:
- Macro: SEQ_LOOP_EN.
- Defined: at the end of a track, rd_ptr wraps to 0 and the track keeps playing until stop_btn.
- Undefined: at the end of a track, its track_playing bit clears on the tick. When both bits are 0, the state returns to IDLE on the next cycle.

Decomposition:
- Shared package synth_pkg holds:
  - seq_entry_t struct {note, octave, accident}
  - seq_state_t enum {IDLE, REC, PLAY}
  - note code constants NOTE_C..NOTE_C_HI
- One sub-module, step_timer (params STEP_CYCLES; ports clk, rst_n, clr, tick). It is cleared on PLAY entry and on play_btn restart.

Test Plan:
- Reset: hold rst_n=0 mid-PLAY -> all outputs 0, state IDLE. play_btn after release is ignored because len=0.
- Record: track_sel=0, rec_btn, then key_press with (2,1,0), (4,1,1), (0,2,0), stop -> len[0]=3. In IDLE, outputs echo live keys with 1-cycle latency.
- Playback (STEP_CYCLES=4): play_btn -> note=2,octave=1 for 4 cycles, then 4,1 accident=1, then 0,2; track_playing=2'b01.
- Full: DEPTH=4, 6 presses -> len=4, entries 0..3 hold the first 4 keys, the 5th and 6th are dropped.
- Priority: stop_btn and play_btn on the same cycle in REC -> IDLE, no playback.
- Loop: SEQ_LOOP_EN defined -> note=2 reappears after the 3rd step. Undefined -> track_playing=0 and IDLE after the 3rd step.
